// File: rtl/clk_switch_pkg.sv
// Shared types and helpers for the break-before-make clock selection controller.
package clk_switch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    ENABLE = 2'd2
  } state_t;

  localparam int MAX_CLK = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic int lowest_set(input logic [MAX_CLK-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_CLK - 1; i >= 0; i--)
      if (v[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/clk_alive_monitor.sv
// Per-source liveness: synchronise the heartbeat toggle, detect edges, and
// flag the source dead after TIMEOUT control cycles without one.
module clk_alive_monitor
  import clk_switch_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic aclk,
  input  logic areset,
  input  logic hb_toggle,
  output logic alive
);

  localparam int CNT_W = clog2(TIMEOUT + 1);

  logic             sync_1, sync_2, prev;
  logic             hb_edge;
  logic [CNT_W-1:0] cnt, cnt_nx;

  assign hb_edge = sync_2 ^ prev;

  always_comb begin
    if (hb_edge)                     cnt_nx = '0;
    else if (cnt == CNT_W'(TIMEOUT)) cnt_nx = cnt;
    else                             cnt_nx = cnt + CNT_W'(1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
      cnt    <= '0;
      alive  <= 1'b1;
    end else begin
      // NOTE: non-blocking so the synchroniser chain shifts one stage per edge.
      sync_1 <= hb_toggle;
      sync_2 <= sync_1;
      prev   <= sync_2;
      cnt    <= cnt_nx;
      alive  <= (cnt_nx < CNT_W'(TIMEOUT));
    end
  end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Selection controller for an N-input BUFGCTRL clock switch: handshake,
// break-before-make sequencing, liveness monitoring and automatic failover.
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int N_CLK         = 4,
  parameter int DEAD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int TIMEOUT       = 64,
  parameter bit AUTO_FAILOVER = 1'b1,
  parameter int DEFAULT_SEL   = 0,
  localparam int SEL_W = (clog2(N_CLK) < 1) ? 1 : clog2(N_CLK)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_sel,
  input  logic [N_CLK-1:0] hb_toggle,
  output logic [N_CLK-1:0] sel_en,
  output logic [SEL_W-1:0] active_sel,
  output logic             switching,
  output logic [N_CLK-1:0] alive,
  output logic             fault,
  output logic             err
);

  localparam int CNT_MAX = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (clog2(CNT_MAX + 1) < 1) ? 1 : clog2(CNT_MAX + 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [SEL_W-1:0]   sel_nx, failover_target;
  logic [N_CLK-1:0]   sel_en_nx, onehot_active, other_alive;
  logic               switching_nx, err_nx, failover_pending;
  logic [MAX_CLK-1:0] other_alive_w;
  // Padded to the full index range so out-of-range requests read as dead.
  logic [(1<<SEL_W)-1:0] alive_ext;

  for (genvar i = 0; i < N_CLK; i++) begin : g_mon
    clk_alive_monitor #(.TIMEOUT(TIMEOUT)) u_mon (
      .aclk      (aclk),
      .areset    (areset),
      .hb_toggle (hb_toggle[i]),
      .alive     (alive[i])
    );
  end

  always_comb begin
    alive_ext              = '0;
    alive_ext[N_CLK-1:0]   = alive;
    other_alive_w          = '0;
    other_alive_w[N_CLK-1:0] = other_alive;
  end

  assign onehot_active    = N_CLK'(1) << active_sel;
  assign other_alive      = alive & ~onehot_active;
  assign failover_target  = SEL_W'(lowest_set(other_alive_w));
  assign failover_pending = AUTO_FAILOVER && fault && (|other_alive);
  assign req_ready        = (state == IDLE) && !failover_pending;

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path infers a latch.
    state_nx     = state;
    cnt_nx       = cnt;
    sel_nx       = active_sel;
    sel_en_nx    = sel_en;
    switching_nx = switching;
    err_nx       = 1'b0;
    case (state)
      IDLE: begin
        if (failover_pending) begin
          sel_nx       = failover_target;
          state_nx     = DRAIN;
          cnt_nx       = '0;
          sel_en_nx    = '0;
          switching_nx = 1'b1;
        end else if (req_valid) begin
          if (!alive_ext[req_sel]) begin
            err_nx = 1'b1;
          end else if (req_sel != active_sel) begin
            sel_nx       = req_sel;
            state_nx     = DRAIN;
            cnt_nx       = '0;
            sel_en_nx    = '0;
            switching_nx = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(DEAD_CYCLES - 1)) begin
          state_nx  = ENABLE;
          cnt_nx    = '0;
          sel_en_nx = onehot_active;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ENABLE: begin
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_nx     = IDLE;
          cnt_nx       = '0;
          switching_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx     = DRAIN;
        cnt_nx       = '0;
        sel_en_nx    = '0;
        switching_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= DRAIN;
      cnt        <= '0;
      active_sel <= SEL_W'(DEFAULT_SEL);
      sel_en     <= '0;
      switching  <= 1'b1;
      fault      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      active_sel <= sel_nx;
      sel_en     <= sel_en_nx;
      switching  <= switching_nx;
      fault      <= !alive_ext[active_sel];
      err        <= err_nx;
    end
  end

endmodule
